// File: rtl/wb_conmax_cfg_loader.sv
// Wishbone initiator that writes a 16-bit value table into the conmax register file.
// Optional read-back check is enabled by defining WB_CONMAX_CFG_VERIFY_EN.
module wb_conmax_cfg_loader #(
  parameter logic [3:0]  rf_addr = 4'hf,
  parameter int unsigned dw      = 32,
  parameter int unsigned aw      = 32,
  parameter int unsigned sw      = dw / 8,
  parameter int unsigned n_regs  = 16,
  parameter int unsigned max_rty = 3,
  parameter int unsigned tmo     = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          fail_o,
  output logic [3:0]    fail_idx_o,
  output logic [3:0]    cfg_idx_o,
  input  logic [15:0]   cfg_data_i,
  output logic [dw-1:0] wb_data_o,
  input  logic [dw-1:0] wb_data_i,
  output logic [aw-1:0] wb_addr_o,
  output logic [sw-1:0] wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  localparam logic [3:0] LastIdx = 4'(n_regs - 1);
  localparam logic [7:0] TmoLast = 8'(tmo - 1);
  localparam logic [7:0] RtyMax  = 8'(max_rty);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWr,
`ifdef WB_CONMAX_CFG_VERIFY_EN
    StRd,
    StChk,
`endif
    StFin
  } state_e;

  state_e        state_q;
  logic [3:0]    idx_q;
  logic [7:0]    rty_cnt_q;
  logic [7:0]    tmo_cnt_q;
  logic          busy_q, done_q, fail_q;
  logic [3:0]    fail_idx_q;
  logic          cyc_q, stb_q, we_q;
  logic [aw-1:0] addr_q;
  logic [dw-1:0] data_q;
  logic [sw-1:0] sel_q;
  logic [aw-1:0] addr_next;

`ifdef WB_CONMAX_CFG_VERIFY_EN
  logic          vrf_q;
  logic [dw-1:0] rd_q;
`else
  logic          unused_rd_data;
  assign unused_rd_data = ^wb_data_i;
`endif

  always_comb begin
    addr_next              = '0;
    addr_next[aw-5:aw-8]   = rf_addr;
    addr_next[5:2]         = idx_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      rty_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      fail_idx_q <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      sel_q      <= '0;
`ifdef WB_CONMAX_CFG_VERIFY_EN
      vrf_q      <= 1'b0;
      rd_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            idx_q     <= '0;
            rty_cnt_q <= '0;
            fail_q    <= 1'b0;
            busy_q    <= 1'b1;
`ifdef WB_CONMAX_CFG_VERIFY_EN
            vrf_q     <= 1'b0;
`endif
            state_q   <= StLoad;
          end
        end
        // One idle bus cycle before every access; the register file needs stb low between beats.
        StLoad: begin
          data_q    <= {{(dw-16){1'b0}}, cfg_data_i};
          addr_q    <= addr_next;
          sel_q     <= '1;
          tmo_cnt_q <= '0;
          cyc_q     <= 1'b1;
          stb_q     <= 1'b1;
`ifdef WB_CONMAX_CFG_VERIFY_EN
          we_q      <= ~vrf_q;
          state_q   <= vrf_q ? StRd : StWr;
`else
          we_q      <= 1'b1;
          state_q   <= StWr;
`endif
        end
`ifdef WB_CONMAX_CFG_VERIFY_EN
        StWr, StRd: begin
`else
        StWr: begin
`endif
          if (wb_err_i || (wb_rty_i && rty_cnt_q == RtyMax) ||
              (!wb_rty_i && !wb_ack_i && tmo_cnt_q == TmoLast)) begin
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            fail_q     <= 1'b1;
            fail_idx_q <= idx_q;
            state_q    <= StFin;
          end else if (wb_rty_i) begin
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            rty_cnt_q <= rty_cnt_q + 8'd1;
            state_q   <= StLoad;
          end else if (wb_ack_i) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
`ifdef WB_CONMAX_CFG_VERIFY_EN
            if (vrf_q) begin
              rd_q    <= wb_data_i;
              state_q <= StChk;
            end else if (idx_q == LastIdx) begin
              vrf_q     <= 1'b1;
              idx_q     <= '0;
              rty_cnt_q <= '0;
              state_q   <= StLoad;
            end else begin
              idx_q     <= idx_q + 4'd1;
              rty_cnt_q <= '0;
              state_q   <= StLoad;
            end
`else
            if (idx_q == LastIdx) begin
              state_q <= StFin;
            end else begin
              idx_q     <= idx_q + 4'd1;
              rty_cnt_q <= '0;
              state_q   <= StLoad;
            end
`endif
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
`ifdef WB_CONMAX_CFG_VERIFY_EN
        StChk: begin
          if (rd_q[15:0] != cfg_data_i || rd_q[dw-1:16] != '0) begin
            fail_q     <= 1'b1;
            fail_idx_q <= idx_q;
            state_q    <= StFin;
          end else if (idx_q == LastIdx) begin
            state_q <= StFin;
          end else begin
            idx_q     <= idx_q + 4'd1;
            rty_cnt_q <= '0;
            state_q   <= StLoad;
          end
        end
`endif
        StFin: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign fail_o     = fail_q;
  assign fail_idx_o = fail_idx_q;
  assign cfg_idx_o  = idx_q;
  assign wb_data_o  = data_q;
  assign wb_addr_o  = addr_q;
  assign wb_sel_o   = sel_q;
  assign wb_we_o    = we_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;

endmodule

// File: tb/tb_wb_conmax_cfg_loader.sv
// Directed bench for wb_conmax_cfg_loader with a scripted Wishbone slave.
// Adds the read-back scenarios when WB_CONMAX_CFG_VERIFY_EN is defined.
module tb_wb_conmax_cfg_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, fail;
  logic [3:0]  fail_idx, cfg_idx;
  logic [15:0] cfg_data;
  logic [31:0] wb_dat_o, wb_dat_i, wb_addr;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic        wb_ack, wb_err, wb_rty;

  wb_conmax_cfg_loader dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .busy_o     (busy),
    .done_o     (done),
    .fail_o     (fail),
    .fail_idx_o (fail_idx),
    .cfg_idx_o  (cfg_idx),
    .cfg_data_i (cfg_data),
    .wb_data_o  (wb_dat_o),
    .wb_data_i  (wb_dat_i),
    .wb_addr_o  (wb_addr),
    .wb_sel_o   (wb_sel),
    .wb_we_o    (wb_we),
    .wb_cyc_o   (wb_cyc),
    .wb_stb_o   (wb_stb),
    .wb_ack_i   (wb_ack),
    .wb_err_i   (wb_err),
    .wb_rty_i   (wb_rty)
  );

  always #5 clk = ~clk;

  assign cfg_data = 16'h1000 + {12'h000, cfg_idx};

`ifdef WB_CONMAX_CFG_VERIFY_EN
  localparam int ExpRises = 32;
`else
  localparam int ExpRises = 16;
`endif

  // Slave script (written only by the initial block)
  int  rty_want [16];
  bit  err_at   [16];
  bit  silent;
  int  corrupt_idx = -1;

  // Slave observations (written only by the slave process)
  int          hits [16];
  int          rty_given [16];
  int          rd_hits, rises, done_cnt, cyc_hi;
  logic [15:0] mem [16];
  logic [31:0] q_addr [$];
  logic [31:0] q_data [$];
  logic        cyc_prev;

  int vectors = 0;
  int miscompares = 0;

  always @(posedge clk) begin
    wb_ack   <= 1'b0;
    wb_err   <= 1'b0;
    wb_rty   <= 1'b0;
    wb_dat_i <= 32'h0;
    cyc_prev <= wb_cyc;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        hits[i]      = 0;
        rty_given[i] = 0;
      end
      rd_hits  = 0;
      rises    = 0;
      done_cnt = 0;
      cyc_hi   = 0;
      q_addr.delete();
      q_data.delete();
    end else begin
      if (wb_cyc && !cyc_prev) rises++;
      if (wb_cyc) cyc_hi++;
      if (done) done_cnt++;
      if (wb_cyc && wb_stb && !(wb_ack || wb_err || wb_rty) && !silent) begin
        if (wb_we) begin
          hits[wb_addr[5:2]]++;
          if (err_at[wb_addr[5:2]]) begin
            wb_err <= 1'b1;
            wb_ack <= 1'b1;
          end else if (rty_given[wb_addr[5:2]] < rty_want[wb_addr[5:2]]) begin
            rty_given[wb_addr[5:2]]++;
            wb_rty <= 1'b1;
          end else begin
            wb_ack <= 1'b1;
            mem[wb_addr[5:2]] = wb_dat_o[15:0];
            q_addr.push_back(wb_addr);
            q_data.push_back(wb_dat_o);
          end
        end else begin
          rd_hits++;
          wb_ack <= 1'b1;
          if (int'(wb_addr[5:2]) == corrupt_idx) wb_dat_i <= 32'h0000_DEAD;
          else wb_dat_i <= {16'h0, mem[wb_addr[5:2]]};
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_script();
    for (int i = 0; i < 16; i++) begin
      rty_want[i] = 0;
      err_at[i]   = 1'b0;
    end
    silent      = 1'b0;
    corrupt_idx = -1;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      tick();
      cycles++;
    end
    check_eq({tag, " done seen"}, {31'h0, done}, 32'h1);
  endtask

  task automatic wait_idx(input logic [3:0] val, input int budget);
    int n = 0;
    while (cfg_idx != val && n < budget) begin
      tick();
      n++;
    end
    check_eq("wait cfg_idx", {28'h0, cfg_idx}, {28'h0, val});
  endtask

  int cyc_n;

  initial begin
    clear_script();

    // Reset state and a clean run
    apply_reset();
    check_eq("rst busy", {31'h0, busy}, 32'h0);
    check_eq("rst done", {31'h0, done}, 32'h0);
    check_eq("rst fail", {31'h0, fail}, 32'h0);
    check_eq("rst cyc/stb/we", {29'h0, wb_cyc, wb_stb, wb_we}, 32'h0);
    check_eq("rst addr", wb_addr, 32'h0);
    check_eq("rst data", wb_dat_o, 32'h0);
    check_eq("rst sel/idx/fidx", {20'h0, wb_sel, cfg_idx, fail_idx}, 32'h0);
    pulse_start();
    check_eq("load busy", {31'h0, busy}, 32'h1);
    check_eq("load cyc", {31'h0, wb_cyc}, 32'h0);
    tick();
    check_eq("wr0 cyc/stb/we", {29'h0, wb_cyc, wb_stb, wb_we}, 32'h7);
    check_eq("wr0 sel", {28'h0, wb_sel}, 32'hf);
    check_eq("wr0 addr", wb_addr, 32'h0F00_0000);
    check_eq("wr0 data", wb_dat_o, 32'h0000_1000);
    wait_done("clean", 400, cyc_n);
`ifndef WB_CONMAX_CFG_VERIFY_EN
    check_eq("clean latency", cyc_n, 32'd48);
`endif
    check_eq("clean busy at done", {31'h0, busy}, 32'h0);
    check_eq("clean fail", {31'h0, fail}, 32'h0);
    check_eq("clean writes", q_addr.size(), 32'd16);
    for (int i = 0; i < 16 && i < q_addr.size(); i++) begin
      check_eq($sformatf("clean addr %0d", i), q_addr[i], 32'h0F00_0000 + 32'(4 * i));
      check_eq($sformatf("clean data %0d", i), q_data[i], 32'h0000_1000 + 32'(i));
    end
    check_eq("clean cyc rises", rises, ExpRises);
    tick();
    check_eq("done one cycle", {31'h0, done}, 32'h0);
    check_eq("done count", done_cnt, 32'd1);

    // Two retries at idx 3 then ack
    clear_script();
    rty_want[3] = 2;
    apply_reset();
    pulse_start();
    wait_done("rty2", 400, cyc_n);
    check_eq("rty2 fail", {31'h0, fail}, 32'h0);
    check_eq("rty2 idx3 issues", hits[3], 32'd3);
    check_eq("rty2 writes", q_addr.size(), 32'd16);

    // Four retries at idx 3 exhaust the budget
    clear_script();
    rty_want[3] = 4;
    apply_reset();
    pulse_start();
    wait_done("rty4", 400, cyc_n);
    check_eq("rty4 fail", {31'h0, fail}, 32'h1);
    check_eq("rty4 fail_idx", {28'h0, fail_idx}, 32'd3);
    check_eq("rty4 idx3 issues", hits[3], 32'd4);
    check_eq("rty4 idx4 issues", hits[4], 32'd0);

    // err together with ack at idx 5
    clear_script();
    err_at[5] = 1'b1;
    apply_reset();
    pulse_start();
    wait_done("err", 400, cyc_n);
    check_eq("err fail", {31'h0, fail}, 32'h1);
    check_eq("err fail_idx", {28'h0, fail_idx}, 32'd5);
    check_eq("err busy", {31'h0, busy}, 32'h0);
    check_eq("err writes", q_addr.size(), 32'd5);
    tick();
    check_eq("err done count", done_cnt, 32'd1);
    check_eq("err fail sticky", {31'h0, fail}, 32'h1);

    // Silent slave at idx 0
    clear_script();
    silent = 1'b1;
    apply_reset();
    pulse_start();
    wait_done("tmo", 600, cyc_n);
    check_eq("tmo fail", {31'h0, fail}, 32'h1);
    check_eq("tmo fail_idx", {28'h0, fail_idx}, 32'd0);
    check_eq("tmo cyc cycles", cyc_hi, 32'd255);
    check_eq("tmo cyc low", {31'h0, wb_cyc}, 32'h0);

    // Start ignored mid-sequence, then reset at idx 7
    clear_script();
    apply_reset();
    pulse_start();
    wait_idx(4'd2, 100);
    pulse_start();
    wait_idx(4'd7, 100);
    check_eq("ign writes at idx7", q_addr.size(), 32'd7);
    check_eq("ign idx0 issues", hits[0], 32'd1);
    tick();
    check_eq("mid cyc high", {31'h0, wb_cyc}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid rst cyc/stb", {30'h0, wb_cyc, wb_stb}, 32'h0);
    check_eq("mid rst busy", {31'h0, busy}, 32'h0);
    check_eq("mid rst idx", {28'h0, cfg_idx}, 32'h0);
    pulse_start();
    check_eq("restart idx", {28'h0, cfg_idx}, 32'h0);
    wait_done("restart", 400, cyc_n);
    check_eq("restart fail", {31'h0, fail}, 32'h0);
    check_eq("restart writes", q_addr.size(), 32'd16);
    if (q_addr.size() > 0) check_eq("restart first addr", q_addr[0], 32'h0F00_0000);

`ifdef WB_CONMAX_CFG_VERIFY_EN
    // Read-back pass with matching data, then with a corrupted word at idx 9
    clear_script();
    apply_reset();
    pulse_start();
    wait_done("vrf ok", 600, cyc_n);
    check_eq("vrf ok fail", {31'h0, fail}, 32'h0);
    check_eq("vrf ok reads", rd_hits, 32'd16);
    check_eq("vrf ok accesses", rises, 32'd32);
    clear_script();
    corrupt_idx = 9;
    apply_reset();
    pulse_start();
    wait_done("vrf bad", 600, cyc_n);
    check_eq("vrf bad fail", {31'h0, fail}, 32'h1);
    check_eq("vrf bad fail_idx", {28'h0, fail_idx}, 32'd9);
    check_eq("vrf bad reads", rd_hits, 32'd10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
